ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the SoC to a keyboard or mouse.
- Uses the standard inhibit / request-to-send / device-clocked frame and checks the device's ack bit.
- Sits beside the PS/2 keyboard receiver and shares the same two open-drain pads through the top-level pad wrapper.
- While tx_busy is high, the receiver must ignore the bus.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles the PS/2 clock is held low before request-to-send (125 us at 48 MHz).
- TIMEOUT_CYCLES, 96000: maximum clk cycles between consecutive device clock falling edges, and the limit for the bus to return idle (2 ms at 48 MHz).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous reset, active-high.
- tx_data  in  8  byte to send; sampled when tx_strb is accepted.
- tx_strb  in  1  one-cycle start request.
- tx_busy  out  1  transfer in progress.
- tx_done  out  1  one-cycle pulse on return to idle (success, ack error or timeout).
- tx_ack_err  out  1  device did not ack; sticky.
- tx_timeout  out  1  device clock or bus-idle timeout; sticky.
- ps2_clk_i  in  1  PS/2 clock pad input (asynchronous).
- ps2_dat_i  in  1  PS/2 data pad input (asynchronous).
- ps2_clk_oe  out  1  1 = drive the clock pad low; 0 = release.
- ps2_dat_oe  out  1  1 = drive the data pad low; 0 = release.

Behaviour:
Input sampling and edge detect:
- ps2_clk_i and ps2_dat_i each pass through a 2-flop synchronizer.
- fall = previous synced clock 1 and current synced clock 0, registered. Pad edge to fall is 3 cycles.
- Data is always sampled from the synced ps2_dat.

Reset:
- All outputs are 0 and the state is IDLE.
- Reset mid-transfer releases both pads on the next clk edge and aborts with no tx_done.

Handshake:
- tx_strb is accepted only in IDLE. A strobe while busy is ignored, with no queueing and no error.
- On acceptance: latch shift reg = {parity, tx_data}, with parity = ~^tx_data (odd parity). Clear tx_ack_err and tx_timeout. Next cycle tx_busy=1, ps2_clk_oe=1, state INHIBIT.

State machine:
- INHIBIT:
  - Counter runs INHIBIT_CYCLES.
  - At terminal count: ps2_dat_oe=1 (start bit 0), bit counter=0, go to RTS.
- RTS:
  - Hold ps2_clk_oe=1 for 1 further cycle, then set ps2_clk_oe=0 and go to DATA.
  - Clear the timeout counter.
- DATA:
  - On each fall, with n = bit counter:
    - n=0..8: ps2_dat_oe = ~shift[n], giving d0..d7 then parity; n increments.
    - n=9: ps2_dat_oe=0 (stop bit, released high); go to ACK.
- ACK:
  - On the next fall, sample data. 0 is a good ack; 1 sets tx_ack_err=1.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clock=1 and data=1 for 2 consecutive cycles.
  - Then tx_done=1 for one cycle, tx_busy=0, state IDLE.

Timeout:
- In DATA, ACK and WAIT_IDLE, a 17-bit counter clears on every fall and increments otherwise.
- Reaching TIMEOUT_CYCLES (a device that never clocks counts too): ps2_clk_oe=0, ps2_dat_oe=0, tx_timeout=1, tx_done pulse, IDLE.
- Timeout takes precedence over a fall in the same cycle.

Line-release rules:
- ps2_clk_oe is never 1 outside INHIBIT and RTS.
- ps2_dat_oe is never 1 outside RTS, DATA and the first ACK cycle.
- Outputs are registered only.

Test Plan:
- Send 0xF4 to a device model (clock period 80 us) that acks.
  - Clock held low ≥6000 cycles, then data low before clock release.
  - Device samples bits 0,0,1,0,1,1,1,1 and parity 0, then stop 1.
  - tx_done pulses once; tx_ack_err=0, tx_timeout=0.
- Send 0xED, then 0x00.
  - Parity bits sampled by the device are 1 and 1.
  - Back-to-back sends work: the second strobe is issued on the cycle after tx_done.
- Device returns ack=1 on byte 0x01.
  - Parity sampled is 0; tx_ack_err=1, tx_done pulses.
  - tx_ack_err clears on the next accepted tx_strb.
- Device never clocks after request-to-send.
  - Exactly TIMEOUT_CYCLES after clock release: tx_timeout=1, both oe=0, tx_done pulse.
  - Device stops after 4 clocks: same response.
- tx_strb is pulsed during DATA with tx_data=0xAA.
  - Ignored: the frame in flight is unchanged and there is exactly one tx_done.
- reset is asserted after bit 5.
  - Next cycle both oe=0, tx_busy=0, no tx_done.
  - A new transfer of 0xFF completes with parity 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : Host-to-device PS/2 transmitter. Sends one command byte to a
//            keyboard or mouse using the inhibit / request-to-send /
//            device-clocked frame, and checks the device's ack bit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock, single domain
//   reset       in   synchronous reset, active-high
//   tx_data     in   [7:0] byte to send, sampled when tx_strb is accepted
//   tx_strb     in   one-cycle start request, accepted only when idle
//   tx_busy     out  transfer in progress (PS/2 receiver must ignore the bus)
//   tx_done     out  one-cycle pulse on return to idle (any outcome)
//   tx_ack_err  out  device did not ack, sticky until the next accepted start
//   tx_timeout  out  device clock / bus-idle timeout, sticky likewise
//   ps2_clk_i   in   PS/2 clock pad input (asynchronous)
//   ps2_dat_i   in   PS/2 data pad input (asynchronous)
//   ps2_clk_oe  out  1 = pull the clock pad low, 0 = release
//   ps2_dat_oe  out  1 = pull the data pad low, 0 = release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_strb,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [16:0]      TO_LAST  = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT = 4'd9;  // stop-bit slot

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // --------------------------------------------------------------------------
  // Pad synchronizers and falling-edge detect
  // --------------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall_q, fall_d;

  // Registered edge flag: pad edge to fall_q is three clk cycles.
  always_comb begin
    fall_d = clk_prev_q & ~clk_s2_q;
  end

  // Synchronizers reset to the idle-bus level so leaving reset never looks
  // like a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
      fall_q     <= fall_d;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,     state_d;
  logic [INH_W-1:0] inh_cnt_q,   inh_cnt_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic [8:0]       shift_q,     shift_d;      // {parity, data}
  logic [16:0]      to_cnt_q,    to_cnt_d;
  logic             idle_seen_q, idle_seen_d;  // bus seen idle last cycle
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             ack_err_q,   ack_err_d;
  logic             timeout_q,   timeout_d;
  logic             clk_oe_q,    clk_oe_d;
  logic             dat_oe_q,    dat_oe_d;

  // Shared transition conditions
  logic in_device_phase;
  logic inh_term;
  logic to_expire;
  logic bus_idle;

  always_comb begin
    in_device_phase = (state_q == ST_DATA) || (state_q == ST_ACK) ||
                      (state_q == ST_WAIT_IDLE);
    inh_term        = (inh_cnt_q == INH_LAST);
    to_expire       = in_device_phase && (to_cnt_q == TO_LAST);
    bus_idle        = clk_s2_q & dat_s2_q;
  end

  // --------------------------------------------------------------------------
  // Process 1: state register (plus the registered outputs and datapath)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      inh_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      idle_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      idle_seen_q <= idle_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      timeout_q   <= timeout_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (tx_strb) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (inh_term) state_d = ST_RTS;
      ST_RTS:       state_d = ST_DATA;
      // Timeout is checked first so it wins over a simultaneous fall.
      ST_DATA: begin
        if (to_expire)                             state_d = ST_IDLE;
        else if (fall_q && (bit_cnt_q == LAST_BIT)) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (to_expire)   state_d = ST_IDLE;
        else if (fall_q) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (to_expire)                     state_d = ST_IDLE;
        else if (bus_idle && idle_seen_q)  state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: output and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    inh_cnt_d   = inh_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    idle_seen_d = idle_seen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;
    timeout_d   = timeout_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d   = 1'b0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_strb) begin
          // Odd parity: the parity bit makes the 9-bit total an odd count.
          shift_d   = {~^tx_data, tx_data};
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
        end
      end

      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_term) begin
          dat_oe_d  = 1'b1;  // start bit (0) while clock is still held
          bit_cnt_d = '0;
        end
      end

      ST_RTS: begin
        clk_oe_d    = 1'b0;  // hand the clock to the device
        to_cnt_d    = '0;
        idle_seen_d = 1'b0;
      end

      ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
        to_cnt_d = fall_q ? 17'd0 : (to_cnt_q + 17'd1);
        if (to_expire) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else if (state_q == ST_DATA) begin
          if (fall_q) begin
            if (bit_cnt_q == LAST_BIT) begin
              dat_oe_d = 1'b0;  // stop bit: release, line floats high
            end else begin
              dat_oe_d  = ~shift_q[bit_cnt_q];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end else if (state_q == ST_ACK) begin
          dat_oe_d = 1'b0;
          if (fall_q) begin
            if (dat_s2_q) ack_err_d = 1'b1;
            idle_seen_d = 1'b0;
          end
        end else begin
          // Bus must read idle on two consecutive cycles before finishing.
          if (bus_idle) begin
            if (idle_seen_q) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end else begin
              idle_seen_d = 1'b1;
            end
          end else begin
            idle_seen_d = 1'b0;
          end
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_ack_err = ack_err_q;
  assign tx_timeout = timeout_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Directed self-checking bench for ps2_host_tx with a simple
//            open-drain PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH  = 30;
  localparam int TO   = 200;
  localparam int HALF = 20;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strb = 1'b0;
  logic       tx_busy, tx_done, tx_ack_err, tx_timeout;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk, ps2_dat;

  // Open-drain bus with pull-ups
  assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_strb    (tx_strb),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_ack_err (tx_ack_err),
    .tx_timeout (tx_timeout),
    .ps2_clk_i  (ps2_clk),
    .ps2_dat_i  (ps2_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [11:0] frame_bits;
  logic snap_ack_err, snap_timeout, snap_busy;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with tx_strb already set; returns at the first
  // negedge where the host has released the clock.
  task automatic wait_rts(input string tag);
    int  low;
    bit  ok;
    logic dat_at_rel;
    low = 0; ok = 0; dat_at_rel = 1'b1;
    for (int k = 0; k < 4 * INH + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_strb      = 1'b0;
        snap_ack_err = tx_ack_err;
        snap_timeout = tx_timeout;
        snap_busy    = tx_busy;
      end
      if (!ps2_clk) low++;
      else if (low > 0) begin
        ok = 1; dat_at_rel = ps2_dat; break;
      end
    end
    chk({tag, "_rts_seen"}, 32'(ok), 32'd1);
    chk({tag, "_inhibit_len"}, 32'(low), 32'(INH + 1));
    chk({tag, "_start_bit_low"}, 32'(dat_at_rel), 32'd0);
  endtask

  task automatic device_clocks(input int nclk, input bit nack, input bit strb_mid);
    for (int i = 1; i <= nclk; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (strb_mid && i == 5) begin
        @(negedge clk); tx_data = 8'hAA; tx_strb = 1'b1;
        @(negedge clk); tx_strb = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      frame_bits[i] = ps2_dat;     // device samples just before rising edge
      dev_clk_low = 1'b0;
      if (i == 10) dev_dat_low = ~nack;
      if (i == 11) dev_dat_low = 1'b0;
    end
  endtask

  // Start a transfer at the current negedge and let the device clock nclk bits.
  task automatic xfer(input string tag, input logic [7:0] b, input bit nack,
                      input int nclk, input bit strb_mid);
    frame_bits = '0;
    tx_data = b;
    tx_strb = 1'b1;
    wait_rts(tag);
    device_clocks(nclk, nack, strb_mid);
  endtask

  // Wait for the tx_done pulse and check the frame the device saw.
  task automatic finish(input string tag, input int d0, input logic [9:0] exp_frame,
                        input logic exp_ack_err);
    bit ok;
    ok = 0;
    for (int k = 0; k < 4 * TO; k++) begin
      @(negedge clk);
      if (tx_done) begin ok = 1; break; end
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_frame"}, 32'(frame_bits[10:1]), 32'(exp_frame));
    chk({tag, "_flags"}, {30'd0, tx_ack_err, tx_timeout}, {30'd0, exp_ack_err, 1'b0});
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_idle_outs"}, {28'd0, tx_done, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  initial begin : main
    int d0;
    int k;
    bit seen;

    // ---- Reset state ----
    repeat (4) @(negedge clk);
    chk("reset_outs", {26'd0, tx_busy, tx_done, tx_ack_err, tx_timeout, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // ---- 0xF4 with ack: d=0,0,1,0,1,1,1,1 parity 0 stop 1 ----
    d0 = done_cnt;
    xfer("f4", 8'hF4, 1'b0, 11, 1'b0);
    chk("f4_busy_on_accept", 32'(snap_busy), 32'd1);
    finish("f4", d0, 10'b1_0_11110100, 1'b0);

    // ---- 0xED then 0x00 back-to-back, both parity 1 ----
    d0 = done_cnt;
    xfer("ed", 8'hED, 1'b0, 11, 1'b0);
    finish("ed", d0, 10'b1_1_11101101, 1'b0);
    d0 = done_cnt;
    xfer("z0", 8'h00, 1'b0, 11, 1'b0);
    finish("z0", d0, 10'b1_1_00000000, 1'b0);

    // ---- 0x01 with nack: parity 0, ack error ----
    d0 = done_cnt;
    xfer("nack", 8'h01, 1'b1, 11, 1'b0);
    finish("nack", d0, 10'b1_0_00000001, 1'b1);

    // ---- Device never clocks: timeout exactly TO cycles after release ----
    d0 = done_cnt;
    xfer("to0", 8'h55, 1'b0, 0, 1'b0);
    chk("ack_err_cleared", 32'(snap_ack_err), 32'd0);
    k = 0; seen = 0;
    for (int j = 1; j <= 2 * TO; j++) begin
      @(negedge clk);
      if (tx_timeout) begin k = j; seen = 1; break; end
    end
    chk("to0_seen", 32'(seen), 32'd1);
    chk("to0_latency", 32'(k), 32'(TO));
    chk("to0_outs", {28'd0, tx_done, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'b1000);
    @(negedge clk);
    chk("to0_done_once", 32'(done_cnt - d0), 32'd1);

    // ---- Device stops after 4 clocks ----
    d0 = done_cnt;
    xfer("to4", 8'h12, 1'b0, 4, 1'b0);
    chk("timeout_cleared", 32'(snap_timeout), 32'd0);
    seen = 0;
    for (int j = 0; j < 2 * TO; j++) begin
      @(negedge clk);
      if (tx_timeout) begin seen = 1; break; end
    end
    chk("to4_seen", 32'(seen), 32'd1);
    chk("to4_outs", {27'd0, tx_done, tx_busy, ps2_clk_oe, ps2_dat_oe, tx_ack_err}, 32'b10000);
    @(negedge clk);
    chk("to4_done_once", 32'(done_cnt - d0), 32'd1);

    // ---- Strobe during DATA with 0xAA is ignored ----
    d0 = done_cnt;
    xfer("mid", 8'h5A, 1'b0, 11, 1'b1);
    finish("mid", d0, 10'b1_1_01011010, 1'b0);

    // ---- Reset after bit 5, then 0xFF ----
    xfer("rst", 8'h3C, 1'b0, 6, 1'b0);
    chk("rst_busy_before", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_outs", {26'd0, tx_busy, tx_done, tx_ack_err, tx_timeout, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    xfer("ff", 8'hFF, 1'b0, 11, 1'b0);
    finish("ff", d0, 10'b1_1_11111111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
